// File: rtl/clk_div_cfg_pkg.sv
// Shared FSM encoding, ratio floor and counter sizing for the clk_div run-time ratio controller.
package clk_div_cfg_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_FALL,
    ST_GATE,
    ST_SETTLE,
    ST_RUN
  } cfg_state_t;

  localparam int MIN_DIV_RATIO      = 2;
  localparam int DEF_SETTLE_CYCLES  = 2;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // One counter serves both the settle hold and the edge-wait timeout.
  function automatic int cfg_cnt_width(input int settle_cycles, input int timeout_cycles);
    int max_cnt;
    max_cnt = (settle_cycles > timeout_cycles) ? settle_cycles : timeout_cycles;
    return (max_cnt < 2) ? 1 : $clog2(max_cnt + 1);
  endfunction

  localparam int CFG_CNT_W = cfg_cnt_width(DEF_SETTLE_CYCLES, DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/clk_div_edge_det.sv
// Falling-edge detector for the divided clock sampled on the system clock.
// Zero-cycle pulse (registered history vs. live input); no backpressure.
module clk_div_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic div_clk,
  output logic fall
);

  logic div_clk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_clk_q <= 1'b0;
    end else begin
      div_clk_q <= div_clk;
    end
  end

  assign fall = div_clk_q & ~div_clk;

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Glitch-free run-time ratio loader for clk_div: gate on a divided-clock fall, load, settle, re-enable.
// Accept->o_done = edge wait + 2 + SETTLE_CYCLES; o_req_ready low while busy; CLK_DIV_CFG_TIMEOUT_EN bounds the wait.
module clk_div_cfg_ctrl
  import clk_div_cfg_pkg::*;
#(
  parameter int DIV_VAL_WIDTH  = 4,
  parameter int DEFAULT_RATIO  = 2,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  input  logic [DIV_VAL_WIDTH-1:0] i_req_ratio,
  output logic                     o_req_ready,
  input  logic                     i_clk_div,
  output logic                     o_div_enable,
  output logic [DIV_VAL_WIDTH-1:0] o_div_ratio,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err
`ifdef CLK_DIV_CFG_TIMEOUT_EN
  ,
  output logic                     o_timeout
`endif
);

  // Never narrower than the default build's counter.
  localparam int CNT_REQ = cfg_cnt_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = (CNT_REQ > CFG_CNT_W) ? CNT_REQ : CFG_CNT_W;

  localparam logic [DIV_VAL_WIDTH-1:0] RATIO_RST   = DIV_VAL_WIDTH'(DEFAULT_RATIO);
  localparam logic [DIV_VAL_WIDTH-1:0] RATIO_MIN   = DIV_VAL_WIDTH'(MIN_DIV_RATIO);
  localparam logic [CNT_W-1:0]         SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef CLK_DIV_CFG_TIMEOUT_EN
  localparam logic [CNT_W-1:0]         TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  cfg_state_t               state;
  logic [DIV_VAL_WIDTH-1:0] held_ratio;
  logic [CNT_W-1:0]         cnt;
  logic                     clk_div_fall;
  logic                     req_accept;

  assign req_accept = i_req_valid & o_req_ready;

  clk_div_edge_det u_edge_det (
    .clk     (i_clk),
    .reset   (i_reset),
    .div_clk (i_clk_div),
    .fall    (clk_div_fall)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_INIT;
      o_div_enable <= 1'b0;
      o_div_ratio  <= RATIO_RST;
      o_req_ready  <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      held_ratio   <= '0;
      cnt          <= '0;
`ifdef CLK_DIV_CFG_TIMEOUT_EN
      o_timeout    <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
`ifdef CLK_DIV_CFG_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      case (state)
        ST_INIT: begin
          state        <= ST_IDLE;
          o_div_enable <= 1'b1;
          o_req_ready  <= 1'b1;
        end
        ST_IDLE: begin
          if (req_accept) begin
            held_ratio <= i_req_ratio;
            if (i_req_ratio < RATIO_MIN) begin
              o_err <= 1'b1;
            end else if (i_req_ratio == o_div_ratio) begin
              o_done <= 1'b1;
            end else begin
              state       <= ST_WAIT_FALL;
              o_busy      <= 1'b1;
              o_req_ready <= 1'b0;
              cnt         <= '0;
            end
          end
        end
        ST_WAIT_FALL: begin
          if (clk_div_fall) begin
            state <= ST_GATE;
`ifdef CLK_DIV_CFG_TIMEOUT_EN
          end else if (cnt == TIMEOUT_LAST) begin
            state     <= ST_GATE;
            o_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        ST_GATE: begin
          // Divider output is low here, so stopping it cannot clip a high phase.
          o_div_enable <= 1'b0;
          o_div_ratio  <= held_ratio;
          cnt          <= '0;
          state        <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          o_div_enable <= 1'b1;
          o_done       <= 1'b1;
          o_busy       <= 1'b0;
          o_req_ready  <= 1'b1;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl driving a behavioural clk_div; pulses checked by a queue-fed monitor.
module tb_clk_div_cfg_ctrl;

  localparam int W      = 4;
  localparam int SETTLE = 2;

  typedef struct packed {
    logic [2:0]   kind;   // {timeout, err, done}
    logic [W-1:0] ratio;
    logic         en;
  } exp_t;

  logic         clk = 1'b0;
  logic         i_reset;
  logic         i_req_valid;
  logic [W-1:0] i_req_ratio;
  logic         o_req_ready;
  logic         i_clk_div;
  logic         o_div_enable;
  logic [W-1:0] o_div_ratio;
  logic         o_busy;
  logic         o_done;
  logic         o_err;
  logic         o_timeout;
  logic         force_low;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t exp_q[$];

  always #1 clk = ~clk;

  clk_div_cfg_ctrl #(
    .DIV_VAL_WIDTH (W),
    .DEFAULT_RATIO (2),
    .SETTLE_CYCLES (SETTLE)
`ifdef CLK_DIV_CFG_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .i_req_ratio (i_req_ratio),
    .o_req_ready (o_req_ready),
    .i_clk_div   (i_clk_div),
    .o_div_enable(o_div_enable),
    .o_div_ratio (o_div_ratio),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
`ifdef CLK_DIV_CFG_TIMEOUT_EN
    ,
    .o_timeout   (o_timeout)
`endif
  );

`ifndef CLK_DIV_CFG_TIMEOUT_EN
  assign o_timeout = 1'b0;
`endif

  // Behavioural clk_div: period = ratio cycles, high for ratio/2, held low while disabled.
  logic [W-1:0] dcnt;
  logic         div_out;

  always_ff @(posedge clk) begin
    if (!o_div_enable) dcnt <= '0;
    else if (dcnt >= o_div_ratio - 1'b1) dcnt <= '0;
    else dcnt <= dcnt + 1'b1;
  end

  assign div_out   = o_div_enable & (dcnt < (o_div_ratio >> 1));
  assign i_clk_div = force_low ? 1'b0 : div_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  function automatic exp_t mk_exp(input logic [2:0] kind, input logic [W-1:0] ratio, input logic en);
    exp_t e;
    e.kind  = kind;
    e.ratio = ratio;
    e.en    = en;
    return e;
  endfunction

  task automatic monitor();
    exp_t       e;
    logic [2:0] ev;
    forever begin
      @(negedge clk);
      ev = {o_timeout, o_err, o_done};
      if (ev != 3'b000) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_event: actual flags %b required none", ev);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 32'(ev), 32'(e.kind));
          check("event_ratio", 32'(o_div_ratio), 32'(e.ratio));
          check("event_enable", 32'(o_div_enable), 32'(e.en));
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input logic [W-1:0] r, output logic prev);
    int w;
    w = 0;
    i_req_valid = 1'b1;
    i_req_ratio = r;
    while (!o_req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_for_send", 32'(o_req_ready), 1);
    prev = i_clk_div;
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  logic         s_tr [12];
  logic         en_tr[12];
  logic         dn_tr[12];
  logic [W-1:0] rt_tr[12];

  initial begin
    #20000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic prev, pv;
    int   n0, first_low, low_cnt, done_idx, r1, r2, k, busy_gap;

    i_reset     = 1'b1;
    i_req_valid = 1'b0;
    i_req_ratio = '0;
    force_low   = 1'b0;
    fork
      monitor();
    join_none

    // 1: reset state, then INIT -> IDLE after one cycle
    repeat (3) @(negedge clk);
    check("rst_ratio", 32'(o_div_ratio), 2);
    check("rst_enable", 32'(o_div_enable), 0);
    check("rst_ready", 32'(o_req_ready), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done_err", 32'({o_done, o_err}), 0);
    i_reset = 1'b0;
    @(negedge clk);
    check("init_enable", 32'(o_div_enable), 1);
    check("init_ready", 32'(o_req_ready), 1);
    repeat (4) @(negedge clk);

    // 2: ratio 5, gated right after a divided-clock fall
    exp_q.push_back(mk_exp(3'b001, 4'd5, 1'b1));
    send(4'd5, prev);
    for (int n = 0; n < 12; n++) begin
      s_tr[n]  = i_clk_div;
      en_tr[n] = o_div_enable;
      dn_tr[n] = o_done;
      rt_tr[n] = o_div_ratio;
      @(negedge clk);
    end
    n0 = -1; first_low = 11; low_cnt = 0; done_idx = -1;
    for (int n = 0; n < 12; n++) begin
      if (n0 < 0 && (n == 0 ? prev : s_tr[n-1]) && !s_tr[n]) n0 = n;
      if (!en_tr[n]) begin
        if (low_cnt == 0) first_low = n;
        low_cnt++;
      end
      if (dn_tr[n] && done_idx < 0) done_idx = n;
    end
    check("fall_seen", 32'(n0 >= 0), 1);
    check("gate_after_fall", first_low, n0 + 2);
    check("gate_low_cycles", low_cnt, SETTLE + 1);
    check("done_latency", done_idx, (n0 + 1) + 2 + SETTLE);
    check("ratio_at_gate", 32'(rt_tr[first_low]), 5);
    r1 = -1; r2 = -1; pv = i_clk_div;
    for (int n = 0; n < 30 && r2 < 0; n++) begin
      @(negedge clk);
      if (!pv && i_clk_div) begin
        if (r1 < 0) r1 = n;
        else r2 = n;
      end
      pv = i_clk_div;
    end
    check("div_period", r2 - r1, 5);

    // 3: ratios 1 and 0 rejected, nothing else moves
    exp_q.push_back(mk_exp(3'b010, 4'd5, 1'b1));
    send(4'd1, prev);
    exp_q.push_back(mk_exp(3'b010, 4'd5, 1'b1));
    send(4'd0, prev);
    repeat (2) @(negedge clk);
    check("err_ratio_kept", 32'(o_div_ratio), 5);
    check("err_enable_kept", 32'(o_div_enable), 1);
    check("err_not_busy", 32'(o_busy), 0);

    // 4: same ratio completes without gating
    exp_q.push_back(mk_exp(3'b001, 4'd5, 1'b1));
    send(4'd5, prev);
    k = 0;
    for (int n = 0; n < 4; n++) begin
      if (!o_div_enable || o_busy) k++;
      @(negedge clk);
    end
    check("same_ratio_no_gate", k, 0);

    // 5: request held during busy waits for IDLE; reset in SETTLE drops it
    exp_q.push_back(mk_exp(3'b001, 4'd7, 1'b1));
    send(4'd7, prev);
    i_req_valid = 1'b1;
    i_req_ratio = 4'd3;
    k = 0; busy_gap = 0;
    while (!o_req_ready && k < 40) begin
      if (!o_busy) busy_gap++;
      @(negedge clk);
      k++;
    end
    check("held_req_waits_busy", busy_gap, 0);
    check("ratio_before_held_accept", 32'(o_div_ratio), 7);
    @(negedge clk);
    i_req_valid = 1'b0;
    check("held_req_accepted", 32'(o_busy), 1);
    k = 0;
    while (o_div_enable && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("settle_ratio", 32'(o_div_ratio), 3);
    i_reset = 1'b1;
    @(negedge clk);
    check("midrst_ratio", 32'(o_div_ratio), 2);
    check("midrst_enable", 32'(o_div_enable), 0);
    check("midrst_busy", 32'(o_busy), 0);
    i_reset = 1'b0;
    @(negedge clk);
    check("midrst_init_exit", 32'({o_div_enable, o_req_ready}), 3);
    repeat (8) @(negedge clk);

`ifdef CLK_DIV_CFG_TIMEOUT_EN
    // 6: divided clock stuck low forces the load after the timeout
    force_low = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(mk_exp(3'b100, 4'd2, 1'b1));
    exp_q.push_back(mk_exp(3'b001, 4'd4, 1'b1));
    send(4'd4, prev);
    k = 0;
    while (!o_timeout && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", k, 8);
    k = 0;
    while (!o_done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("timeout_done_ratio", 32'(o_div_ratio), 4);
    force_low = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
